// File: rtl/ecc_point_validator.sv
// Checks that an affine point (xq, yq) lies on y^2 + xy = x^3 + ax^2 + b over GF(2^M).
// A single MSB-first bit-serial multiplier is time-shared across three products.
module ecc_point_validator #(
    parameter int           M        = 163,
    parameter logic [M-1:0] POLY_LOW = 163'hC9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic [M-1:0] xq,
    input  logic [M-1:0] yq,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic         is_inf
);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, CMP, DONE} state_t;

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [M-1:0] acc_q, acc_d;
    logic [M-1:0] a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d;
    logic [M-1:0] l_q, l_d, t_q, t_d;
    logic         valid_q, valid_d, inf_q, inf_d;

    logic [M-1:0] mul_a, mul_b, acc_shift, prod;
    logic [7:0]   bit_idx;
    logic         mul_bit, last_bit, zero_pt;

    // Operand routing for the shared multiplier: mul_a is scanned MSB-first.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL1: begin mul_a = y_q; mul_b = y_q ^ x_q; end
            MUL2: begin mul_a = x_q; mul_b = x_q;       end
            MUL3: begin mul_a = t_q; mul_b = x_q ^ a_q; end
            default: ;
        endcase
        bit_idx   = 8'(M - 1) - cnt_q;
        mul_bit   = mul_a[bit_idx];
        acc_shift = {acc_q[M-2:0], 1'b0} ^ (acc_q[M-1] ? POLY_LOW : '0);
        prod      = acc_shift ^ (mul_bit ? mul_b : '0);
        last_bit  = (cnt_q == 8'(M - 1));
        zero_pt   = (x_q == '0) && (y_q == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        y_d     = y_q;
        l_d     = l_q;
        t_d     = t_q;
        valid_d = valid_q;
        inf_d   = inf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    x_d     = xq;
                    y_d     = yq;
                    acc_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    inf_d   = 1'b0;
                    // The point at infinity skips the multiplier and resolves in the compare slot.
                    state_d = (xq == '0 && yq == '0) ? CMP : MUL1;
                end
            end
            MUL1, MUL2, MUL3: begin
                acc_d = prod;
                cnt_d = cnt_q + 8'd1;
                if (last_bit) begin
                    cnt_d = '0;
                    if (state_q == MUL1) begin
                        l_d     = prod;
                        acc_d   = '0;
                        state_d = MUL2;
                    end else if (state_q == MUL2) begin
                        t_d     = prod;
                        acc_d   = '0;
                        state_d = MUL3;
                    end else begin
                        state_d = CMP;
                    end
                end
            end
            CMP: begin
                if (zero_pt) begin
                    valid_d = 1'b1;
                    inf_d   = 1'b1;
                end else begin
                    valid_d = (l_q == (acc_q ^ b_q));
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            l_q     <= '0;
            t_q     <= '0;
            valid_q <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            l_q     <= l_d;
            t_q     <= t_d;
            valid_q <= valid_d;
            inf_q   <= inf_d;
        end
    end

    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);
    assign valid  = valid_q;
    assign is_inf = inf_q;

endmodule

// File: tb/tb_ecc_point_validator.sv
// Randomized self-checking bench for ecc_point_validator against a polynomial-arithmetic
// reference model (full carry-less product followed by long-division reduction).
module tb_ecc_point_validator;

    localparam int M = 163;
    localparam logic [163:0] FPOLY = {1'b1, 163'hC9};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [M-1:0] a = '0, b = '0, xq = '0, yq = '0;
    logic         busy, done, valid, is_inf;

    int checks = 0;
    int errors = 0;

    ecc_point_validator dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .xq(xq), .yq(yq),
        .busy(busy), .done(done), .valid(valid), .is_inf(is_inf)
    );

    always #5 clk = ~clk;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] u, input logic [M-1:0] v);
        logic [324:0] p;
        p = '0;
        for (int i = 0; i < M; i++)
            if (v[i]) p ^= ({162'b0, u} << i);
        for (int i = 324; i >= M; i--)
            if (p[i]) p ^= ({161'b0, FPOLY} << (i - M));
        return p[M-1:0];
    endfunction

    function automatic logic model_valid(input logic [M-1:0] ca, input logic [M-1:0] cb,
                                         input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] x2, lhs, rhs;
        if (x == '0 && y == '0) return 1'b1;
        x2  = gf_mul(x, x);
        lhs = gf_mul(y, y) ^ gf_mul(x, y);
        rhs = gf_mul(x2, x) ^ gf_mul(ca, x2) ^ cb;
        return lhs == rhs;
    endfunction

    function automatic logic [M-1:0] curve_b(input logic [M-1:0] ca, input logic [M-1:0] x,
                                             input logic [M-1:0] y);
        logic [M-1:0] x2;
        x2 = gf_mul(x, x);
        return gf_mul(y, y) ^ gf_mul(x, y) ^ gf_mul(x2, x) ^ gf_mul(ca, x2);
    endfunction

    function automatic logic [M-1:0] rand163();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[M-1:0];
    endfunction

    task automatic launch(input logic [M-1:0] ca, input logic [M-1:0] cb,
                          input logic [M-1:0] x, input logic [M-1:0] y);
        @(posedge clk); #1;
        a = ca; b = cb; xq = x; yq = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = rand163(); b = rand163(); xq = rand163(); yq = rand163();
    endtask

    // lat = negedges after the launch edge until done (-1 on timeout); busy_bad counts busy errors.
    task automatic wait_done(output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                if (busy) busy_bad++;
                break;
            end else if (!busy) busy_bad++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, valid, is_inf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {busy, done, valid, is_inf});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [M-1:0] ta [4], tb_ [4], tx [4], ty [4];
        int lat, bb;
        logic ev;
        ta[0] = 163'd0; tb_[0] = 163'd1; tx[0] = 163'd1; ty[0] = 163'd1;
        ta[1] = 163'd1; tb_[1] = 163'd1; tx[1] = 163'd1; ty[1] = 163'd0;
        ta[2] = 163'd1; tb_[2] = 163'h20A601907B8C953CA1481EB10512F78744A3205FD;
        tx[2] = 163'h3F0EBA16286A2D57EA0991168D4994637E8343E36;
        ty[2] = 163'h0D51FBC6C71A0094FA2CDD545B11C5C0C797324F1;
        ta[3] = ta[2]; tb_[3] = tb_[2]; tx[3] = tx[2]; ty[3] = ty[2] ^ 163'd1;
        for (int i = 0; i < 4; i++) begin
            ev = model_valid(ta[i], tb_[i], tx[i], ty[i]);
            launch(ta[i], tb_[i], tx[i], ty[i]);
            wait_done(lat, bb);
            checks++;
            if (lat !== 490) begin errors++; $display("FAIL directed%0d_latency: got %0d expected 490", i, lat); end
            checks++;
            if (bb !== 0) begin errors++; $display("FAIL directed%0d_busy: got %0d bad cycles expected 0", i, bb); end
            checks++;
            if ({valid, is_inf} !== {ev, 1'b0}) begin
                errors++; $display("FAIL directed%0d_result: got %b expected %b", i, {valid, is_inf}, {ev, 1'b0});
            end
            @(negedge clk);
            checks++;
            if ({done, valid} !== {1'b0, ev}) begin
                errors++; $display("FAIL directed%0d_hold: got %b expected %b", i, {done, valid}, {1'b0, ev});
            end
        end
    endtask

    task automatic test_random();
        logic [M-1:0] ca, cb, x, y;
        int lat, bb;
        logic ev;
        for (int i = 0; i < 8; i++) begin
            ca = rand163(); x = rand163(); y = rand163();
            cb = (i % 2 == 0) ? curve_b(ca, x, y) : rand163();
            ev = model_valid(ca, cb, x, y);
            launch(ca, cb, x, y);
            wait_done(lat, bb);
            checks++;
            if (lat !== 490 || bb !== 0) begin
                errors++; $display("FAIL random%0d_timing: got lat=%0d busy_bad=%0d expected 490/0", i, lat, bb);
            end
            checks++;
            if ({valid, is_inf} !== {ev, 1'b0}) begin
                errors++; $display("FAIL random%0d_result: got %b expected %b", i, {valid, is_inf}, {ev, 1'b0});
            end
        end
    endtask

    task automatic test_x_zero();
        logic [M-1:0] y, cb;
        int lat, bb;
        logic ev;
        for (int i = 0; i < 2; i++) begin
            y  = rand163() | 163'd1;
            cb = gf_mul(y, y) ^ ((i == 1) ? 163'd1 : 163'd0);
            ev = model_valid(rand163(), cb, '0, y);
            launch(rand163(), cb, '0, y);
            wait_done(lat, bb);
            checks++;
            if ({lat == 490, valid, is_inf} !== {1'b1, ev, 1'b0}) begin
                errors++; $display("FAIL xzero%0d: got lat=%0d valid=%b inf=%b expected 490/%b/0", i, lat, valid, is_inf, ev);
            end
        end
    endtask

    task automatic test_infinity();
        int lat, bb;
        launch(rand163(), rand163(), '0, '0);
        wait_done(lat, bb);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL inf_latency: got %0d expected 1", lat); end
        checks++;
        if ({valid, is_inf, busy} !== 3'b110) begin
            errors++; $display("FAIL inf_result: got %b expected 110", {valid, is_inf, busy});
        end
    endtask

    task automatic test_ignored_starts();
        logic [M-1:0] ca, cb, x, y;
        int lat, bb, extra;
        logic ev;
        ca = rand163(); x = rand163(); y = rand163(); cb = curve_b(ca, x, y) ^ 163'd4;
        ev = model_valid(ca, cb, x, y);
        launch(ca, cb, x, y);
        repeat (199) @(posedge clk);
        #1; a = '0; b = '0; xq = '0; yq = '0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(lat, bb);
        checks++;
        if (lat !== 290 || bb !== 0) begin
            errors++; $display("FAIL ignore_mul2: got lat=%0d busy_bad=%0d expected 290/0", lat, bb);
        end
        checks++;
        if ({valid, is_inf} !== {ev, 1'b0}) begin
            errors++; $display("FAIL ignore_result: got %b expected %b", {valid, is_inf}, {ev, 1'b0});
        end
        xq = '0; yq = '0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done || valid !== ev) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ignore_done_start: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [M-1:0] ca, x, y;
        int lat, bb;
        ca = rand163(); x = rand163(); y = rand163();
        launch(rand163(), rand163(), '0, '0);
        wait_done(lat, bb);
        launch(ca, curve_b(ca, x, y), x, y);
        wait_done(lat, bb);
        checks++;
        if ({lat == 490, bb == 0, valid, is_inf} !== 4'b1110) begin
            errors++; $display("FAIL back_to_back: got lat=%0d busy_bad=%0d valid=%b inf=%b expected 490/0/1/0", lat, bb, valid, is_inf);
        end
    endtask

    task automatic test_reset_midop();
        logic [M-1:0] ca, x, y;
        int lat, bb, seen;
        ca = rand163(); x = rand163(); y = rand163();
        launch(ca, curve_b(ca, x, y), x, y);
        repeat (199) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, valid, is_inf} !== 4'b0000) begin
            errors++; $display("FAIL reset_midop: got %b expected 0000", {busy, done, valid, is_inf});
        end
        #1; rst = 1'b0;
        seen = 0;
        repeat (600) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_abandon: got %0d active cycles expected 0", seen); end
        launch(ca, curve_b(ca, x, y), x, y);
        wait_done(lat, bb);
        checks++;
        if ({lat == 490, valid, is_inf} !== 3'b110) begin
            errors++; $display("FAIL reset_recover: got lat=%0d valid=%b inf=%b expected 490/1/0", lat, valid, is_inf);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_x_zero();
        test_infinity();
        test_ignored_starts();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
